// File: rtl/crp16_alu_divider.sv
// rtl/crp16_alu_divider.sv - Multi-cycle restoring divider (unsigned/signed) for the crp16 ALU
module crp16_alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             v
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] dmag;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    logic             x_neg, y_neg, div_zero, ovf, ge, last_iter;
    logic [WIDTH-1:0] x_mag, y_mag, rem_next, a_next, q_fix, r_fix;
    logic [WIDTH:0]   p_shift;

    always_comb begin
        x_neg     = sgn & x[WIDTH-1];
        y_neg     = sgn & y[WIDTH-1];
        x_mag     = x_neg ? -x : x;
        y_mag     = y_neg ? -y : y;
        div_zero  = (y == '0);
        ovf       = sgn && (x == MIN_NEG) && (y == '1);
        // Remainder after a subtract is always below the divisor, so WIDTH bits hold it.
        p_shift   = {p, a[WIDTH-1]};
        ge        = (p_shift >= {1'b0, dmag});
        rem_next  = ge ? (p_shift[WIDTH-1:0] - dmag) : p_shift[WIDTH-1:0];
        a_next    = {a[WIDTH-2:0], ge};
        q_fix     = neg_q ? -a_next : a_next;
        r_fix     = neg_r ? -rem_next : rem_next;
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            a     <= '0;
            p     <= '0;
            dmag  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            v     <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        if (div_zero) begin
                            q     <= '1;
                            r     <= x;
                            dz    <= 1'b1;
                            v     <= 1'b0;
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (ovf) begin
                            q     <= MIN_NEG;
                            r     <= '0;
                            dz    <= 1'b0;
                            v     <= 1'b1;
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            a     <= x_mag;
                            dmag  <= y_mag;
                            p     <= '0;
                            cnt   <= '0;
                            neg_q <= x_neg ^ y_neg;
                            neg_r <= x_neg;
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    p   <= rem_next;
                    a   <= a_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        q     <= q_fix;
                        r     <= r_fix;
                        dz    <= 1'b0;
                        v     <= 1'b0;
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
